aes_wb_sequencer: RTL and testbench
===================================

Name: aes_wb_sequencer

Overview:
- Wishbone master that sits directly upstream of the AES encrypt control slave and drives its register map.
- Accepts a 128-bit key and plaintext block on a valid/ready request port, then loads the key, holds the core in reset while loading plaintext, and releases it.
- Polls status until the core reports ready, reads back the 128-bit ciphertext, and presents it on a valid/ready response port.
- Lets a stream source use the encrypt slave without CPU involvement.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base address of the encrypt slave; offsets are added to it.
- POLL_MAX, 64, maximum number of status reads before a timeout is declared (range 1..65535).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle and able to accept a request
- req_key_load  in  1  1 = write req_key before the block; 0 = reuse the key already in the slave
- req_key  in  128  key, word i = bits [32i+31:32i]
- req_pt  in  128  plaintext, same word order
- rsp_valid  out  1  ciphertext/result available
- rsp_ready  in  1  consumer accepts result
- rsp_ct  out  128  ciphertext, word i from read of offset 0x030+4i
- rsp_error  out  1  poll timeout occurred
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  1 = write
- wbm_sel_o  out  4  always 4'hF
- wbm_adr_o  out  32  BASE_ADDR + offset
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  slave acknowledge

Behaviour:
- Reset values: all outputs 0, except req_ready = 1 and wbm_sel_o = 4'hF; FSM in IDLE; latched key, plaintext and ciphertext are 0.
- All outputs are registered.
- IDLE: req_ready = 1. On req_valid & req_ready:
  - latch req_key, req_pt and req_key_load; req_ready drops the next cycle;
  - go to KEY if key_load = 1, else go to HOLD.
- Transfer protocol (every bus access):
  - ISSUE: cyc/stb = 1, adr/we/dat stable until wbm_ack_i is sampled 1.
  - Then GAP: exactly one cycle with cyc/stb = 0, during which wbm_ack_i is ignored. The slave keeps ack high for one cycle after stb falls, and GAP absorbs that stale ack.
  - On a read, data is captured at the edge where ack is sampled in ISSUE.
  - With a one-cycle-latency slave, each transfer takes 3 cycles.
- KEY: writes offsets 0x010, 0x014, 0x018, 0x01C with key words 0..3, then goes to HOLD.
- HOLD: writes offset 0x004 (core reset asserted), data 0, then goes to PT.
- PT: writes offsets 0x020..0x02C with plaintext words 0..3, then goes to REL.
- REL: writes offset 0x008 (core reset released), data 0, then goes to POLL.
- POLL: reads offset 0x000.
  - If bit0 = 1, go to RD.
  - Otherwise increment poll_cnt. When poll_cnt reaches POLL_MAX with bit0 still 0, set rsp_error = 1, set rsp_ct = 0, and go to RSP.
  - poll_cnt clears on entry to POLL.
- RD: reads offsets 0x030..0x03C into ciphertext words 0..3, then goes to RSP with rsp_error = 0.
- RSP: rsp_valid = 1 and rsp_ct/rsp_error are held stable until rsp_valid & rsp_ready. On that handshake, go to IDLE and raise req_ready the next cycle.
- Back-to-back requests: a new request is accepted at the earliest in the cycle after the RSP handshake. No overlap, no queuing.
- The word counter is 2 bits and wraps 3 to 0 on leaving each multi-word state.
- wbm_ack_i arriving while in IDLE, RSP or GAP is ignored.
- Reset asserted mid-transfer: cyc/stb drop asynchronously, any partial result is discarded, and the FSM returns to IDLE. The slave state is not otherwise recovered; the next request always issues HOLD before PT.
- req_valid must remain asserted until accepted. Changes to req_* inputs after acceptance have no effect.

Test Plan:
- Key 0x000102030405060708090a0b0c0d0e0f, plaintext 0x00112233445566778899aabbccddeeff, key_load = 1, slave model with ready after 3 polls:
  - bus shows exactly writes 0x010–0x01C, 0x004, 0x020–0x02C, 0x008, then 3 reads of 0x000, then reads 0x030–0x03C;
  - rsp_ct = 0x69c4e0d86a7b0430d8cdb78070b4c55a, rsp_error = 0.
- Second request with key_load = 0: no accesses to 0x010–0x01C occur; first bus access is the write to 0x004.
- Slave model never sets ready, POLL_MAX = 4: exactly 4 reads of 0x000, then rsp_valid with rsp_error = 1 and rsp_ct = 0.
- Slave model holds ack high one cycle after stb falls: every register is written exactly once per request, and no read captures stale data.
- rsp_ready held 0 for 10 cycles: rsp_valid and rsp_ct stay stable and req_ready stays 0; one cycle after the handshake, req_ready = 1.
- wb_rst_i asserted during the PT write of 0x024: cyc/stb drop immediately, req_ready = 1 after release; the next request completes correctly, starting with the write to 0x004.

Source files
------------

// File: rtl/aes_wb_sequencer.sv
// aes_wb_sequencer: Wishbone master that runs one AES encryption on the
// encrypt control slave per request. It optionally loads the key, holds the
// core in reset while loading plaintext, releases it, polls status, reads
// back the ciphertext and returns it on a valid/ready response port.
// Ports:
//   wb_clk_i, wb_rst_i                 clock, async active-high reset
//   req_valid/req_ready                request handshake
//   req_key_load, req_key, req_pt      request payload (word i = bits 32i+:32)
//   rsp_valid/rsp_ready                response handshake
//   rsp_ct, rsp_error                  ciphertext, poll-timeout flag
//   wbm_*                              Wishbone master bus
module aes_wb_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned POLL_MAX  = 64
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_key_load,
  input  logic [127:0] req_key,
  input  logic [127:0] req_pt,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_ct,
  output logic         rsp_error,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic [31:0]  wbm_dat_i,
  input  logic         wbm_ack_i
);

  localparam int unsigned PCW = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_KEY  = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_PT   = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;
  localparam logic [2:0] S_POLL = 3'd5;
  localparam logic [2:0] S_RD   = 3'd6;
  localparam logic [2:0] S_RSP  = 3'd7;

  logic [2:0]     state, state_n;
  logic           gap, gap_n;         // 1 = bus idle cycle before next launch
  logic [1:0]     wcnt, wcnt_n;
  logic [PCW-1:0] poll_cnt, poll_cnt_n;
  logic [127:0]   key_q, key_n, pt_q, pt_n, ct_q, ct_n;

  logic           cyc_n, stb_n, we_n, req_ready_n, rsp_valid_n, rsp_error_n;
  logic [31:0]    adr_n, dat_n;
  logic [127:0]   rsp_ct_n;

  logic [7:0]     x_off;
  logic           x_we;
  logic [31:0]    x_dat;
  logic [PCW:0]   poll_inc;

  // Offset, direction and write data of the access for the current state/word
  always_comb begin
    x_off = 8'h00;
    x_we  = 1'b0;
    x_dat = 32'h0;
    case (state)
      S_KEY:  begin x_off = {4'h1, wcnt, 2'b00}; x_we = 1'b1; x_dat = key_q[{wcnt, 5'd0} +: 32]; end
      S_HOLD: begin x_off = 8'h04; x_we = 1'b1; end
      S_PT:   begin x_off = {4'h2, wcnt, 2'b00}; x_we = 1'b1; x_dat = pt_q[{wcnt, 5'd0} +: 32]; end
      S_REL:  begin x_off = 8'h08; x_we = 1'b1; end
      S_RD:   x_off = {4'h3, wcnt, 2'b00};
      default: ;
    endcase
  end

  assign poll_inc = (PCW+1)'(poll_cnt) + (PCW+1)'(1);

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    gap_n       = gap;
    wcnt_n      = wcnt;
    poll_cnt_n  = poll_cnt;
    key_n       = key_q;
    pt_n        = pt_q;
    ct_n        = ct_q;
    cyc_n       = wbm_cyc_o;
    stb_n       = wbm_stb_o;
    we_n        = wbm_we_o;
    adr_n       = wbm_adr_o;
    dat_n       = wbm_dat_o;
    req_ready_n = req_ready;
    rsp_valid_n = rsp_valid;
    rsp_ct_n    = rsp_ct;
    rsp_error_n = rsp_error;

    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          key_n       = req_key;
          pt_n        = req_pt;
          req_ready_n = 1'b0;
          wcnt_n      = 2'd0;
          gap_n       = 1'b1;
          state_n     = req_key_load ? S_KEY : S_HOLD;
        end
      end
      S_RSP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_n = 1'b0;
          req_ready_n = 1'b1;
          state_n     = S_IDLE;
        end
      end
      default: begin
        if (gap) begin
          // Launch the access; the cycle spent in gap swallows any stale ack
          cyc_n = 1'b1;
          stb_n = 1'b1;
          we_n  = x_we;
          adr_n = BASE_ADDR + 32'(x_off);
          dat_n = x_dat;
          gap_n = 1'b0;
        end else if (wbm_ack_i) begin
          cyc_n = 1'b0;
          stb_n = 1'b0;
          gap_n = 1'b1;
          case (state)
            S_KEY: begin
              wcnt_n = wcnt + 2'd1;
              if (wcnt == 2'd3) state_n = S_HOLD;
            end
            S_HOLD: state_n = S_PT;
            S_PT: begin
              wcnt_n = wcnt + 2'd1;
              if (wcnt == 2'd3) state_n = S_REL;
            end
            S_REL: begin
              poll_cnt_n = '0;
              state_n    = S_POLL;
            end
            S_POLL: begin
              if (wbm_dat_i[0]) begin
                wcnt_n  = 2'd0;
                state_n = S_RD;
              end else begin
                poll_cnt_n = poll_inc[PCW-1:0];
                if (poll_inc == (PCW+1)'(POLL_MAX)) begin
                  rsp_error_n = 1'b1;
                  rsp_ct_n    = '0;
                  rsp_valid_n = 1'b1;
                  state_n     = S_RSP;
                end
              end
            end
            S_RD: begin
              ct_n[{wcnt, 5'd0} +: 32] = wbm_dat_i;
              wcnt_n = wcnt + 2'd1;
              if (wcnt == 2'd3) begin
                rsp_error_n = 1'b0;
                rsp_ct_n    = ct_n;
                rsp_valid_n = 1'b1;
                state_n     = S_RSP;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      gap       <= 1'b0;
      wcnt      <= 2'd0;
      poll_cnt  <= '0;
      key_q     <= '0;
      pt_q      <= '0;
      ct_q      <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'hF;
      wbm_adr_o <= 32'h0;
      wbm_dat_o <= 32'h0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_ct    <= '0;
      rsp_error <= 1'b0;
    end else begin
      state     <= state_n;
      gap       <= gap_n;
      wcnt      <= wcnt_n;
      poll_cnt  <= poll_cnt_n;
      key_q     <= key_n;
      pt_q      <= pt_n;
      ct_q      <= ct_n;
      wbm_cyc_o <= cyc_n;
      wbm_stb_o <= stb_n;
      wbm_we_o  <= we_n;
      wbm_sel_o <= 4'hF;
      wbm_adr_o <= adr_n;
      wbm_dat_o <= dat_n;
      req_ready <= req_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_ct    <= rsp_ct_n;
      rsp_error <= rsp_error_n;
    end
  end

endmodule

// File: tb/tb_aes_wb_sequencer.sv
// tb_aes_wb_sequencer: directed bench for aes_wb_sequencer with a behavioural
// encrypt slave (one-cycle ack latency, ack held one cycle after stb falls).
module tb_aes_wb_sequencer;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_key_load = 1'b0;
  logic [127:0] req_key = '0;
  logic [127:0] req_pt = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_ct;
  logic         rsp_error;
  logic         wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]   wbm_sel_o;
  logic [31:0]  wbm_adr_o, wbm_dat_o;
  logic [31:0]  wbm_dat_i;
  logic         wbm_ack_i = 1'b0;

  int checks = 0;
  int failures = 0;

  aes_wb_sequencer #(.BASE_ADDR(BASE), .POLL_MAX(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_key_load(req_key_load),
    .req_key(req_key), .req_pt(req_pt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ct(rsp_ct), .rsp_error(rsp_error),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Slave model
  int          ready_after = 3;   // status reads until ready (0 = never)
  int          stat_cnt = 0;
  logic [31:0] log_adr[$];
  logic        log_we[$];
  logic [31:0] log_dat[$];
  logic [31:0] off;
  logic        stat_ready;

  assign off = wbm_adr_o - BASE;
  assign stat_ready = (ready_after != 0) && (stat_cnt >= ready_after - 1);

  always @(posedge wb_clk_i) begin
    wbm_ack_i <= wbm_cyc_o & wbm_stb_o;
    if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
      log_adr.push_back(wbm_adr_o);
      log_we.push_back(wbm_we_o);
      log_dat.push_back(wbm_we_o ? wbm_dat_o : wbm_dat_i);
      if (wbm_we_o && off == 32'h8) stat_cnt <= 0;
      else if (!wbm_we_o && off == 32'h0) stat_cnt <= stat_cnt + 1;
    end
  end

  // Read data is garbage outside a live acked read so stale captures show up
  always_comb begin
    wbm_dat_i = 32'hDEADBEEF;
    if (wbm_stb_o && wbm_ack_i && !wbm_we_o) begin
      if (off == 32'h0) wbm_dat_i = {31'd0, stat_ready};
      else if (off >= 32'h30 && off <= 32'h3C) wbm_dat_i = CT[{off[3:2], 5'd0} +: 32];
    end
  end

  // Expected bus trace
  logic [31:0] exp_adr[$];
  logic        exp_we[$];
  logic [31:0] exp_dat[$];

  function automatic void exp_clear();
    exp_adr.delete(); exp_we.delete(); exp_dat.delete();
  endfunction

  function automatic void exp_add(input logic [31:0] o, input logic w, input logic [31:0] d);
    exp_adr.push_back(BASE + o); exp_we.push_back(w); exp_dat.push_back(d);
  endfunction

  function automatic void exp_build(input logic kl, input logic [127:0] k,
                                    input logic [127:0] p, input int polls, input logic done);
    logic [31:0] o;
    exp_clear();
    if (kl) for (int i = 0; i < 4; i++) begin
      o = 32'h10 + 32'(4 * i); exp_add(o, 1'b1, k[32*i +: 32]);
    end
    exp_add(32'h4, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      o = 32'h20 + 32'(4 * i); exp_add(o, 1'b1, p[32*i +: 32]);
    end
    exp_add(32'h8, 1'b1, 32'h0);
    for (int i = 0; i < polls; i++) exp_add(32'h0, 1'b0, (done && i == polls - 1) ? 32'h1 : 32'h0);
    if (done) for (int i = 0; i < 4; i++) begin
      o = 32'h30 + 32'(4 * i); exp_add(o, 1'b0, CT[32*i +: 32]);
    end
  endfunction

  // Drivers
  task automatic drive_req(input logic kl, input logic [127:0] k, input logic [127:0] p,
                           output bit ok);
    int n = 0;
    @(negedge wb_clk_i);
    req_valid = 1'b1; req_key_load = kl; req_key = k; req_pt = p;
    while (!req_ready && n < 100) begin @(negedge wb_clk_i); n++; end
    ok = req_ready;
    @(negedge wb_clk_i);
    req_valid = 1'b0;
    req_key = {$urandom, $urandom, $urandom, $urandom};
    req_pt = {$urandom, $urandom, $urandom, $urandom};
    req_key_load = ~kl;
  endtask

  task automatic wait_rsp(output bit ok);
    int n = 0;
    while (!rsp_valid && n < 500) begin @(negedge wb_clk_i); n++; end
    ok = rsp_valid;
  endtask

  task automatic release_rsp();
    @(negedge wb_clk_i); rsp_ready = 1'b1;
    @(negedge wb_clk_i); rsp_ready = 1'b0;
  endtask

  task automatic check_trace(input string name, input int base);
    checks++;
    if (log_adr.size() - base != exp_adr.size()) begin
      failures++;
      $display("FAIL %s count: got %0d accesses, want %0d", name, log_adr.size() - base, exp_adr.size());
    end
    for (int i = 0; i < exp_adr.size(); i++) begin
      checks++;
      if (base + i >= log_adr.size() || log_adr[base+i] !== exp_adr[i] ||
          log_we[base+i] !== exp_we[i] || log_dat[base+i] !== exp_dat[i]) begin
        failures++;
        if (base + i >= log_adr.size())
          $display("FAIL %s access %0d: missing, want adr=%h we=%b", name, i, exp_adr[i], exp_we[i]);
        else
          $display("FAIL %s access %0d: got adr=%h we=%b dat=%h, want adr=%h we=%b dat=%h", name, i,
                   log_adr[base+i], log_we[base+i], log_dat[base+i], exp_adr[i], exp_we[i], exp_dat[i]);
      end
    end
  endtask

  // Tests
  task automatic test_reset();
    @(negedge wb_clk_i);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_ct !== '0 ||
        wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 || wbm_sel_o !== 4'hF ||
        wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_values: got rdy=%b vld=%b err=%b ct=%h cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h, want rdy=1 sel=f rest 0",
               req_ready, rsp_valid, rsp_error, rsp_ct, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o);
    end
  endtask

  task automatic test_key_load();
    bit ok; int base = log_adr.size();
    ready_after = 3;
    drive_req(1'b1, KEY, PT, ok);
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL key_load_ready_drop: got %b want 0", req_ready); end
    wait_rsp(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL key_load_rsp_timeout: rsp_valid got 0 want 1"); end
    exp_build(1'b1, KEY, PT, 3, 1'b1);
    check_trace("key_load", base);
    checks++;
    if (rsp_ct !== CT || rsp_error !== 1'b0) begin
      failures++; $display("FAIL key_load_result: got ct=%h err=%b want ct=%h err=0", rsp_ct, rsp_error, CT);
    end
    release_rsp();
  endtask

  task automatic test_back_to_back();
    bit ok; int base = log_adr.size();
    drive_req(1'b0, 128'hFFFF, PT, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_accept: req_ready got 0 want 1"); end
    wait_rsp(ok);
    exp_build(1'b0, KEY, PT, 3, 1'b1);
    check_trace("no_key_load", base);
    checks++;
    if (rsp_ct !== CT || rsp_error !== 1'b0) begin
      failures++; $display("FAIL no_key_load_result: got ct=%h err=%b want ct=%h err=0", rsp_ct, rsp_error, CT);
    end
    release_rsp();
  endtask

  task automatic test_timeout();
    bit ok; int base = log_adr.size();
    logic [127:0] p = 128'hA5A5A5A5_11111111_22222222_33333333;
    ready_after = 0;
    drive_req(1'b0, KEY, p, ok);
    wait_rsp(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL timeout_rsp: rsp_valid got 0 want 1"); end
    exp_build(1'b0, KEY, p, 4, 1'b0);
    check_trace("timeout", base);
    checks++;
    if (rsp_error !== 1'b1 || rsp_ct !== '0) begin
      failures++; $display("FAIL timeout_result: got err=%b ct=%h want err=1 ct=0", rsp_error, rsp_ct);
    end
    release_rsp();
    ready_after = 3;
  endtask

  task automatic test_rsp_stall();
    bit ok;
    drive_req(1'b1, KEY, PT, ok);
    wait_rsp(ok);
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk_i);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_ct !== CT || rsp_error !== 1'b0 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL rsp_stall cycle %0d: got vld=%b ct=%h err=%b rdy=%b want vld=1 ct=%h err=0 rdy=0",
                 i, rsp_valid, rsp_ct, rsp_error, req_ready, CT);
      end
    end
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rsp_handshake: got rdy=%b vld=%b want rdy=1 vld=0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; bit hit = 0; int base;
    drive_req(1'b0, KEY, PT, ok);
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge wb_clk_i);
      if (wbm_cyc_o && wbm_stb_o && wbm_adr_o == BASE + 32'h24) hit = 1;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL reset_mid_reach: write to 0x024 got none want one"); end
    #1 wb_rst_i = 1'b1;
    #1;
    checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
      failures++; $display("FAIL reset_mid_async: got cyc=%b stb=%b want 0 0", wbm_cyc_o, wbm_stb_o);
    end
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL reset_mid_idle: got rdy=%b vld=%b want 1 0", req_ready, rsp_valid);
    end
    base = log_adr.size();
    drive_req(1'b0, KEY, PT, ok);
    wait_rsp(ok);
    exp_build(1'b0, KEY, PT, 3, 1'b1);
    check_trace("after_reset", base);
    checks++;
    if (rsp_ct !== CT || rsp_error !== 1'b0) begin
      failures++; $display("FAIL after_reset_result: got ct=%h err=%b want ct=%h err=0", rsp_ct, rsp_error, CT);
    end
    release_rsp();
  endtask

  initial begin
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    test_reset();
    test_key_load();
    test_back_to_back();
    test_timeout();
    test_rsp_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
